// File: rtl/miter_pkg.sv
// Shared types for the skew-tolerant lockstep miter: mismatch causes,
// comparator FSM states and per-channel buffer ownership.
package miter_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_DATA     = 2'd1,
    CAUSE_OVERFLOW = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } cause_e;

  typedef enum logic {
    ST_CHECK = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  typedef enum logic {
    OWN_REF = 1'b0,
    OWN_UUT = 1'b1
  } owner_e;

endpackage

// File: rtl/miter_lag_fifo.sv
// Single-channel skew buffer: stores whichever side runs ahead, matches the
// lagging side against the head and reports DATA/OVERFLOW/TIMEOUT causes.
module miter_lag_fifo
  import miter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_LAG = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              ref_valid_i,
  input  logic [DATA_W-1:0] ref_data_i,
  input  logic              uut_valid_i,
  input  logic [DATA_W-1:0] uut_data_i,
  output cause_e            cause_o,
  output logic [DATA_W-1:0] ref_val_o,
  output logic [DATA_W-1:0] uut_val_o,
  output logic              pending_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;
  localparam int GW = $clog2(MAX_LAG + 1);
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);
  localparam logic [GW-1:0] LAG_LIM  = GW'(MAX_LAG);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [OW-1:0]     occ_q, occ_d;
  logic [GW-1:0]     age_q, age_d;
  owner_e            owner_q, owner_d;
  logic              push, pop, empty, full, own_v, opp_v;
  logic [DATA_W-1:0] own_d, opp_d, head, push_val;

  always_comb begin
    empty    = (occ_q == '0);
    full     = (occ_q == FULL_OCC);
    head     = mem_q[rd_ptr_q];
    own_v    = (owner_q == OWN_REF) ? ref_valid_i : uut_valid_i;
    opp_v    = (owner_q == OWN_REF) ? uut_valid_i : ref_valid_i;
    own_d    = (owner_q == OWN_REF) ? ref_data_i  : uut_data_i;
    opp_d    = (owner_q == OWN_REF) ? uut_data_i  : ref_data_i;
    push     = 1'b0;
    pop      = 1'b0;
    push_val = own_d;
    owner_d  = owner_q;
    cause_o  = CAUSE_NONE;
    ref_val_o = '0;
    uut_val_o = '0;
    if (en_i && !clr_i) begin
      if (empty) begin
        if (ref_valid_i && uut_valid_i) begin
          ref_val_o = ref_data_i;
          uut_val_o = uut_data_i;
          if (ref_data_i != uut_data_i) cause_o = CAUSE_DATA;
        end else if (ref_valid_i || uut_valid_i) begin
          push     = 1'b1;
          push_val = ref_valid_i ? ref_data_i : uut_data_i;
          owner_d  = ref_valid_i ? OWN_REF : OWN_UUT;
        end
      end else begin
        pop  = opp_v;
        // A push into a full buffer is dropped unless the head leaves this cycle.
        push = own_v && !(full && !opp_v);
        if (opp_v) begin
          ref_val_o = (owner_q == OWN_REF) ? head  : opp_d;
          uut_val_o = (owner_q == OWN_REF) ? opp_d : head;
          if (head != opp_d) cause_o = CAUSE_DATA;
        end else begin
          ref_val_o = (owner_q == OWN_REF) ? head : '0;
          uut_val_o = (owner_q == OWN_REF) ? '0   : head;
          if (own_v && full)         cause_o = CAUSE_OVERFLOW;
          else if (age_q == LAG_LIM) cause_o = CAUSE_TIMEOUT;
        end
      end
    end
    occ_d = occ_q + OW'(push) - OW'(pop);
    age_d = age_q;
    if (en_i) begin
      if (pop || (push && empty))          age_d = '0;
      else if (!empty && age_q != LAG_LIM) age_d = age_q + GW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      age_q    <= '0;
      owner_q  <= OWN_REF;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      age_q    <= '0;
      owner_q  <= OWN_REF;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q   <= occ_d;
      age_q   <= age_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_val;
  end

  assign pending_o = !empty;

endmodule

// File: rtl/miter_skew_cmp.sv
// Skew-tolerant lockstep miter: one lag buffer per channel, lowest-index
// priority encoding and a sticky first-mismatch record.
module miter_skew_cmp
  import miter_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_LAG = 16,
  parameter int CNT_W   = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic [NUM_CH-1:0]        ref_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] ref_data_i,
  input  logic [NUM_CH-1:0]        uut_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] uut_data_i,
  output logic                     mismatch_o,
  output logic [CH_W-1:0]          mis_ch_o,
  output logic [1:0]               mis_cause_o,
  output logic [CNT_W-1:0]         mis_cycle_o,
  output logic [DATA_W-1:0]        mis_ref_o,
  output logic [DATA_W-1:0]        mis_uut_o,
  output logic [NUM_CH-1:0]        pending_o
);

  cause_e            ch_cause [NUM_CH];
  logic [DATA_W-1:0] ch_ref   [NUM_CH];
  logic [DATA_W-1:0] ch_uut   [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    miter_lag_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .MAX_LAG(MAX_LAG)
    ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (enable_i),
      .clr_i      (clear_i),
      .ref_valid_i(ref_valid_i[c]),
      .ref_data_i (ref_data_i[c*DATA_W +: DATA_W]),
      .uut_valid_i(uut_valid_i[c]),
      .uut_data_i (uut_data_i[c*DATA_W +: DATA_W]),
      .cause_o    (ch_cause[c]),
      .ref_val_o  (ch_ref[c]),
      .uut_val_o  (ch_uut[c]),
      .pending_o  (pending_o[c])
    );
  end

  logic              hit;
  logic [CH_W-1:0]   hit_ch;
  cause_e            hit_cause;
  logic [DATA_W-1:0] hit_ref, hit_uut;

  // Scan high to low so the lowest failing channel wins.
  always_comb begin
    hit       = 1'b0;
    hit_ch    = '0;
    hit_cause = CAUSE_NONE;
    hit_ref   = '0;
    hit_uut   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (ch_cause[c] != CAUSE_NONE) begin
        hit       = 1'b1;
        hit_ch    = CH_W'(c);
        hit_cause = ch_cause[c];
        hit_ref   = ch_ref[c];
        hit_uut   = ch_uut[c];
      end
    end
  end

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic              cap;
  logic [CH_W-1:0]   mis_ch_q;
  cause_e            mis_cause_q;
  logic [CNT_W-1:0]  mis_cycle_q;
  logic [DATA_W-1:0] mis_ref_q, mis_uut_q;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    cap     = 1'b0;
    if (enable_i && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    if (clear_i) begin
      state_d = ST_CHECK;
    end else begin
      case (state_q)
        ST_CHECK: if (hit) begin
          state_d = ST_HOLD;
          cap     = 1'b1;
        end
        ST_HOLD:  state_d = ST_HOLD;
        default:  state_d = ST_CHECK;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      state_q     <= ST_CHECK;
      mis_ch_q    <= '0;
      mis_cause_q <= CAUSE_NONE;
      mis_cycle_q <= '0;
      mis_ref_q   <= '0;
      mis_uut_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      if (clear_i) begin
        mis_ch_q    <= '0;
        mis_cause_q <= CAUSE_NONE;
        mis_cycle_q <= '0;
        mis_ref_q   <= '0;
        mis_uut_q   <= '0;
      end else if (cap) begin
        mis_ch_q    <= hit_ch;
        mis_cause_q <= hit_cause;
        mis_cycle_q <= cnt_q;
        mis_ref_q   <= hit_ref;
        mis_uut_q   <= hit_uut;
      end
    end
  end

  assign mismatch_o  = (state_q == ST_HOLD);
  assign mis_ch_o    = mis_ch_q;
  assign mis_cause_o = mis_cause_q;
  assign mis_cycle_o = mis_cycle_q;
  assign mis_ref_o   = mis_ref_q;
  assign mis_uut_o   = mis_uut_q;

endmodule
